// File: rtl/layer_compositor.sv
// Priority-based sprite/layer compositor: picks the highest-priority visible layer per pixel,
// applies clipping, blinking and a timed background flash, and looks the colour up in a small palette.
module layer_compositor #(
  parameter int NUM_LAYERS   = 8,
  parameter int COLOR_W      = 4,
  parameter int BLINK_FRAMES = 8,
  parameter int FLASH_FRAMES = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                pix_en,
  input  logic                                blank,
  input  logic                                frame_start,
  input  logic [NUM_LAYERS-1:0]               layer_hit,
  input  logic [NUM_LAYERS-1:0]               layer_clip,
  input  logic                                outside_display,
  input  logic                                transparent_outside,
  input  logic [NUM_LAYERS-1:0]               blink_mask,
  input  logic                                flash_trigger,
  input  logic                                cfg_we,
  input  logic [$clog2(NUM_LAYERS+2)-1:0]     cfg_addr,
  input  logic [3*COLOR_W-1:0]                cfg_data,
  output logic [COLOR_W-1:0]                  RED,
  output logic [COLOR_W-1:0]                  GREEN,
  output logic [COLOR_W-1:0]                  BLUE,
  output logic                                out_blank,
  output logic [$clog2(NUM_LAYERS+1)-1:0]     out_layer
);

  localparam int LW        = $clog2(NUM_LAYERS+1);
  localparam int AW        = $clog2(NUM_LAYERS+2);
  localparam int PW        = 3*COLOR_W;
  localparam int NE        = NUM_LAYERS+2;
  localparam int FLASH_IDX = NUM_LAYERS+1;
  localparam int FCW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int FLW       = $clog2(FLASH_FRAMES+1);
  localparam logic [LW-1:0]      BG_IDX   = LW'(NUM_LAYERS);
  localparam logic [COLOR_W-1:0] FLASH_CH = COLOR_W'(((1 << COLOR_W) - 1) >> 2);

  // Lowest set index wins; an empty vector resolves to the background.
  function automatic logic [LW-1:0] first_set(input logic [NUM_LAYERS-1:0] v);
    logic [LW-1:0] idx;
    idx = BG_IDX;
    for (int i = NUM_LAYERS-1; i >= 0; i--) begin
      if (v[i]) idx = LW'(i);
    end
    return idx;
  endfunction

  function automatic logic [FLW-1:0] sat_dec(input logic [FLW-1:0] v);
    return (v == '0) ? v : v - FLW'(1);
  endfunction

  logic [FCW-1:0]        frame_cnt;
  logic                  blink_phase;
  logic [FLW-1:0]        flash_cnt;
  logic                  flash_active;
  logic [PW-1:0]         pal [NE];

  logic [NUM_LAYERS-1:0] clip_mask;
  logic [NUM_LAYERS-1:0] blink_kill;
  logic [NUM_LAYERS-1:0] eff_p0;

  logic [LW-1:0]         win_p1;
  logic                  blank_p1;
  logic [PW-1:0]         color_sel;

  logic [PW-1:0]         color_p2;
  logic                  blank_p2;
  logic [LW-1:0]         layer_p2;

  assign flash_active = (flash_cnt != '0);

  // Frame-rate timers: blink phase and flash countdown.
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      flash_cnt   <= '0;
    end else if (pix_en) begin
      if (frame_start) begin
        if (frame_cnt == FCW'(BLINK_FRAMES-1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FCW'(1);
        end
      end
      if (flash_trigger) begin
        flash_cnt <= FLW'(FLASH_FRAMES);
      end else if (frame_start) begin
        flash_cnt <= sat_dec(flash_cnt);
      end
    end
  end

  // Palette writes are not gated by pix_en; reads see the pre-write value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NE; i++) begin
        if (i < NUM_LAYERS)       pal[i] <= '1;
        else if (i == NUM_LAYERS) pal[i] <= '0;
        else                      pal[i] <= {3{FLASH_CH}};
      end
    end else if (cfg_we && (int'(cfg_addr) < NE)) begin
      pal[cfg_addr] <= cfg_data;
    end
  end

  // Stage 0 -> 1: visibility masking and priority selection.
  always_comb begin
    clip_mask  = (outside_display && !transparent_outside) ? layer_clip : '0;
    blink_kill = blink_phase ? blink_mask : '0;
    eff_p0     = layer_hit & ~clip_mask & ~blink_kill;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      win_p1   <= BG_IDX;
      blank_p1 <= 1'b1;
    end else if (pix_en) begin
      win_p1   <= blank ? BG_IDX : first_set(eff_p0);
      blank_p1 <= blank;
    end
  end

  // Stage 1 -> 2: palette lookup with blank and flash overrides.
  always_comb begin
    color_sel = pal[win_p1];
    if (blank_p1) begin
      color_sel = '0;
    end else if ((win_p1 == BG_IDX) && flash_active) begin
      color_sel = pal[FLASH_IDX];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      color_p2 <= '0;
      blank_p2 <= 1'b1;
      layer_p2 <= BG_IDX;
    end else if (pix_en) begin
      color_p2 <= color_sel;
      blank_p2 <= blank_p1;
      layer_p2 <= win_p1;
    end
  end

  assign RED       = color_p2[PW-1 -: COLOR_W];
  assign GREEN     = color_p2[2*COLOR_W-1 -: COLOR_W];
  assign BLUE      = color_p2[COLOR_W-1:0];
  assign out_blank = blank_p2;
  assign out_layer = layer_p2;

endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor: directed scenarios with fixed expectations plus a randomized
// run checked against a per-pixel reference model (queue of in-flight pixels, integer timers).
module tb_layer_compositor;
  localparam int NL = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, pix_en, blank, frame_start;
  logic          outside_display, transparent_outside, flash_trigger, cfg_we;
  logic [NL-1:0] layer_hit, layer_clip, blink_mask;
  logic [3:0]    cfg_addr;
  logic [11:0]   cfg_data;
  logic [3:0]    red, green, blue;
  logic          out_blank;
  logic [3:0]    out_layer;
  logic [16:0]   obs;

  assign obs = {red, green, blue, out_blank, out_layer};

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct { int win; bit blank; } pix_t;
  pix_t        pipe[$];
  logic [11:0] m_pal [NL+2];
  int          m_frames, m_flash;
  bit          m_phase;
  logic [11:0] exp_rgb;
  logic        exp_blank;
  logic [3:0]  exp_layer;

  layer_compositor dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .blank(blank), .frame_start(frame_start),
    .layer_hit(layer_hit), .layer_clip(layer_clip), .outside_display(outside_display),
    .transparent_outside(transparent_outside), .blink_mask(blink_mask),
    .flash_trigger(flash_trigger), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .RED(red), .GREEN(green), .BLUE(blue), .out_blank(out_blank), .out_layer(out_layer)
  );

  // Advance the reference model for the coming edge, then let the edge happen.
  task automatic tick();
    pix_t cur, nxt;
    bit   clipped, blinked;
    if (!reset) begin
      pipe.delete();
      cur.win = NL; cur.blank = 1'b1;
      pipe.push_back(cur);
      for (int i = 0; i < NL+2; i++)
        m_pal[i] = (i < NL) ? 12'hFFF : ((i == NL) ? 12'h000 : 12'h333);
      m_frames = 0; m_phase = 1'b0; m_flash = 0;
      exp_rgb = 12'h000; exp_blank = 1'b1; exp_layer = 4'(NL);
    end else begin
      if (pix_en) begin
        cur = pipe.pop_front();
        exp_blank = cur.blank;
        exp_layer = 4'(cur.win);
        if (cur.blank)                        exp_rgb = 12'h000;
        else if (cur.win == NL && m_flash > 0) exp_rgb = m_pal[NL+1];
        else                                  exp_rgb = m_pal[cur.win];
        nxt.win = NL; nxt.blank = blank;
        if (!blank) begin
          for (int i = 0; i < NL; i++) begin
            clipped = outside_display && !transparent_outside && layer_clip[i];
            blinked = m_phase && blink_mask[i];
            if (layer_hit[i] && !clipped && !blinked) begin
              nxt.win = i;
              break;
            end
          end
        end
        pipe.push_back(nxt);
        if (flash_trigger)                  m_flash = 16;
        else if (frame_start && m_flash > 0) m_flash = m_flash - 1;
        if (frame_start) begin
          m_frames = m_frames + 1;
          if (m_frames == 8) begin
            m_frames = 0;
            m_phase  = !m_phase;
          end
        end
      end
      if (cfg_we && cfg_addr <= NL+1) m_pal[cfg_addr] = cfg_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    reset = 1'b1; pix_en = 1'b1; blank = 1'b0; frame_start = 1'b0;
    layer_hit = '0; layer_clip = '0; blink_mask = '0;
    outside_display = 1'b0; transparent_outside = 1'b0; flash_trigger = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
  endtask

  task automatic apply_reset();
    set_idle();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b0; cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 12'h000;
    flash_trigger = 1'b1; layer_hit = '1;
    tick(); tick();
    n_cmp++;
    if (obs !== {12'h000, 1'b1, 4'd8}) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", obs, {12'h000, 1'b1, 4'd8});
    end
    reset = 1'b1; cfg_we = 1'b0; flash_trigger = 1'b0; layer_hit = 8'h01;
    tick();
    n_cmp++;
    if (obs !== {12'h000, 1'b1, 4'd8}) begin
      n_fail++; $display("FAIL reset_first_out: got %h want %h", obs, {12'h000, 1'b1, 4'd8});
    end
    tick();
    n_cmp++;
    if (obs !== {12'hFFF, 1'b0, 4'd0}) begin
      n_fail++; $display("FAIL reset_layer_pal: got %h want %h", obs, {12'hFFF, 1'b0, 4'd0});
    end
    layer_hit = '0;
    tick(); tick();
    n_cmp++;
    if (obs !== {12'h000, 1'b0, 4'd8}) begin
      n_fail++; $display("FAIL reset_bg_noflash: got %h want %h", obs, {12'h000, 1'b0, 4'd8});
    end
    flash_trigger = 1'b1;
    tick();
    flash_trigger = 1'b0;
    tick();
    n_cmp++;
    if (obs !== {12'h333, 1'b0, 4'd8}) begin
      n_fail++; $display("FAIL reset_flash_pal: got %h want %h", obs, {12'h333, 1'b0, 4'd8});
    end
  endtask

  task automatic test_priority();
    set_idle();
    layer_hit = 8'b0010_0100; cfg_we = 1'b1; cfg_addr = 4'd2; cfg_data = 12'h5A3;
    tick();
    cfg_we = 1'b0;
    tick();
    n_cmp++;
    if (obs !== {12'h5A3, 1'b0, 4'd2}) begin
      n_fail++; $display("FAIL priority_l2: got %h want %h", obs, {12'h5A3, 1'b0, 4'd2});
    end
    layer_hit = 8'h80;
    tick(); tick();
    n_cmp++;
    if (obs !== {12'hFFF, 1'b0, 4'd7}) begin
      n_fail++; $display("FAIL priority_l7: got %h want %h", obs, {12'hFFF, 1'b0, 4'd7});
    end
  endtask

  task automatic test_clip();
    set_idle();
    layer_clip = 8'h01; layer_hit = 8'h03; outside_display = 1'b1; transparent_outside = 1'b0;
    tick(); tick();
    n_cmp++;
    if (obs !== {12'hFFF, 1'b0, 4'd1}) begin
      n_fail++; $display("FAIL clip_on: got %h want %h", obs, {12'hFFF, 1'b0, 4'd1});
    end
    transparent_outside = 1'b1;
    tick(); tick();
    n_cmp++;
    if (obs !== {12'hFFF, 1'b0, 4'd0}) begin
      n_fail++; $display("FAIL clip_transparent: got %h want %h", obs, {12'hFFF, 1'b0, 4'd0});
    end
    transparent_outside = 1'b0; outside_display = 1'b0;
    tick(); tick();
    n_cmp++;
    if (obs !== {12'hFFF, 1'b0, 4'd0}) begin
      n_fail++; $display("FAIL clip_inside: got %h want %h", obs, {12'hFFF, 1'b0, 4'd0});
    end
  endtask

  task automatic test_blank_stall();
    set_idle();
    blank = 1'b1; layer_hit = '1;
    tick(); tick();
    n_cmp++;
    if (obs !== {12'h000, 1'b1, 4'd8}) begin
      n_fail++; $display("FAIL blank_out: got %h want %h", obs, {12'h000, 1'b1, 4'd8});
    end
    pix_en = 1'b0; blank = 1'b0; layer_hit = 8'h04;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (obs !== {12'h000, 1'b1, 4'd8}) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got %h want %h", i, obs, {12'h000, 1'b1, 4'd8});
      end
    end
    pix_en = 1'b1;
    tick();
    n_cmp++;
    if (obs !== {12'h000, 1'b1, 4'd8}) begin
      n_fail++; $display("FAIL stall_resume1: got %h want %h", obs, {12'h000, 1'b1, 4'd8});
    end
    tick();
    n_cmp++;
    if (obs !== {12'h5A3, 1'b0, 4'd2}) begin
      n_fail++; $display("FAIL stall_resume2: got %h want %h", obs, {12'h5A3, 1'b0, 4'd2});
    end
  endtask

  task automatic test_blink();
    logic [16:0] want;
    apply_reset();
    layer_hit = 8'h08; blink_mask = 8'h08;
    tick(); tick();
    n_cmp++;
    if (obs !== {12'hFFF, 1'b0, 4'd3}) begin
      n_fail++; $display("FAIL blink_start: got %h want %h", obs, {12'hFFF, 1'b0, 4'd3});
    end
    for (int p = 1; p <= 16; p++) begin
      frame_start = 1'b1; tick();
      frame_start = 1'b0; tick(); tick();
      if (p == 7 || p == 8 || p == 15 || p == 16) begin
        want = (p == 8 || p == 15) ? {12'h000, 1'b0, 4'd8} : {12'hFFF, 1'b0, 4'd3};
        n_cmp++;
        if (obs !== want) begin
          n_fail++; $display("FAIL blink_pulse%0d: got %h want %h", p, obs, want);
        end
      end
    end
  endtask

  task automatic test_collision();
    set_idle();
    cfg_we = 1'b1; cfg_addr = 4'd2; cfg_data = 12'h123; layer_hit = 8'h04;
    tick();
    cfg_we = 1'b0;
    tick(); tick();
    n_cmp++;
    if (obs !== {12'h123, 1'b0, 4'd2}) begin
      n_fail++; $display("FAIL collision_setup: got %h want %h", obs, {12'h123, 1'b0, 4'd2});
    end
    cfg_we = 1'b1; cfg_data = 12'h9BC;
    tick();
    cfg_we = 1'b0;
    n_cmp++;
    if (obs !== {12'h123, 1'b0, 4'd2}) begin
      n_fail++; $display("FAIL collision_old: got %h want %h", obs, {12'h123, 1'b0, 4'd2});
    end
    tick();
    n_cmp++;
    if (obs !== {12'h9BC, 1'b0, 4'd2}) begin
      n_fail++; $display("FAIL collision_new: got %h want %h", obs, {12'h9BC, 1'b0, 4'd2});
    end
  endtask

  task automatic test_flash();
    logic [16:0] want;
    apply_reset();
    cfg_we = 1'b1; cfg_addr = 4'd9; cfg_data = 12'h444;
    tick();
    cfg_we = 1'b0; flash_trigger = 1'b1;
    tick();
    flash_trigger = 1'b0;
    tick();
    n_cmp++;
    if (obs !== {12'h444, 1'b0, 4'd8}) begin
      n_fail++; $display("FAIL flash_start: got %h want %h", obs, {12'h444, 1'b0, 4'd8});
    end
    for (int k = 1; k <= 16; k++) begin
      frame_start = 1'b1; tick();
      frame_start = 1'b0; tick(); tick();
      want = (k < 16) ? {12'h444, 1'b0, 4'd8} : {12'h000, 1'b0, 4'd8};
      n_cmp++;
      if (obs !== want) begin
        n_fail++; $display("FAIL flash_frame%0d: got %h want %h", k, obs, want);
      end
    end
  endtask

  task automatic test_retrigger();
    logic [16:0] want;
    apply_reset();
    cfg_we = 1'b1; cfg_addr = 4'd9; cfg_data = 12'h444;
    tick();
    cfg_we = 1'b0; flash_trigger = 1'b1;
    tick();
    flash_trigger = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      frame_start = 1'b1; tick();
      frame_start = 1'b0; tick();
    end
    flash_trigger = 1'b1; frame_start = 1'b1;
    tick();
    flash_trigger = 1'b0; frame_start = 1'b0;
    tick(); tick();
    n_cmp++;
    if (obs !== {12'h444, 1'b0, 4'd8}) begin
      n_fail++; $display("FAIL retrig_reload: got %h want %h", obs, {12'h444, 1'b0, 4'd8});
    end
    for (int k = 1; k <= 16; k++) begin
      frame_start = 1'b1; tick();
      frame_start = 1'b0; tick(); tick();
      want = (k < 16) ? {12'h444, 1'b0, 4'd8} : {12'h000, 1'b0, 4'd8};
      n_cmp++;
      if (obs !== want) begin
        n_fail++; $display("FAIL retrig_frame%0d: got %h want %h", k, obs, want);
      end
    end
  endtask

  task automatic test_random();
    logic [16:0] want;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      reset               = ($urandom_range(99) != 0);
      pix_en              = ($urandom_range(3) != 0);
      blank               = ($urandom_range(7) == 0);
      frame_start         = ($urandom_range(7) == 0);
      layer_hit           = 8'($urandom & $urandom);
      layer_clip          = 8'($urandom);
      blink_mask          = 8'($urandom);
      outside_display     = 1'($urandom);
      transparent_outside = ($urandom_range(3) == 0);
      flash_trigger       = ($urandom_range(63) == 0);
      cfg_we              = ($urandom_range(15) == 0);
      cfg_addr            = 4'($urandom_range(15));
      cfg_data            = 12'($urandom);
      tick();
      want = {exp_rgb, exp_blank, exp_layer};
      n_cmp++;
      if (obs !== want) begin
        n_fail++; $display("FAIL random_cycle%0d: got %h want %h", c, obs, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_clip();
    test_blank_stall();
    test_blink();
    test_collision();
    test_flash();
    test_retrigger();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
